// File: rtl/debug_port_arbiter_pkg.sv
// Shared definitions for the debug-port arbiter: FSM state encoding and requester ids.
package debug_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    ACK     = 3'd4
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/debug_port_arbiter_if.sv
// Requester-side handshake bundle for the two debug-port clients (host loader and peripheral engine).
interface debug_port_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );
endinterface

// File: rtl/debug_port_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin on ties, or fixed priority to requester 0.
module rr_pick2
  import debug_port_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic id
);

  always_comb begin
    valid = req0 | req1;
    id    = REQ0;
    if (req0 && req1) begin
      id = ROUND_ROBIN ? ~last_gnt : REQ0;
    end else if (req1) begin
      id = REQ1;
    end
  end

endmodule

// File: rtl/debug_port_arbiter.sv
// Shares the block RAM debug port between two requesters; sequences sync reads and
// single-cycle writes, and owns the bidirectional RAM data bus.
module debug_port_arbiter
  import debug_port_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int AW          = 11,
  parameter int DW          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  debug_port_arbiter_if.slave   req_if,
  output logic                  busy,
  output logic                  gnt_id,
  output logic                  ram_en,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [AW-1:0]         ram_addr,
  inout  wire  [DW-1:0]         ram_data
);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_read_q, ram_read_d;
  logic          ram_write_q, ram_write_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          pick_valid;
  logic          pick_id;

  rr_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .req0     (req_if.req0),
    .req1     (req_if.req1),
    .last_gnt (last_gnt_q),
    .valid    (pick_valid),
    .id       (pick_id)
  );

  // ram_addr_q doubles as the latched request address for the whole access.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wdata_d    = wdata_q;
    ram_addr_d = ram_addr_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d      = pick_id;
          ram_addr_d = pick_id ? req_if.addr1 : req_if.addr0;
          wdata_d    = pick_id ? req_if.wdata1 : req_if.wdata0;
          state_d    = (pick_id ? req_if.we1 : req_if.we0) ? WR : RD_ADDR;
        end
      end
      WR:      state_d = ACK;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        if (gnt_q == REQ1) rdata1_d = ram_data;
        else               rdata0_d = ram_data;
        state_d = ACK;
      end
      ACK: begin
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so every RAM pin comes straight off a flop.
    ram_en_d    = (state_d == WR) || (state_d == RD_ADDR) || (state_d == RD_DATA);
    ram_write_d = (state_d == WR);
    ram_read_d  = (state_d == RD_ADDR) || (state_d == RD_DATA);
    ack0_d      = (state_d == ACK) && (gnt_d == REQ0);
    ack1_d      = (state_d == ACK) && (gnt_d == REQ1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= REQ0;
      last_gnt_q  <= REQ1;
      wdata_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      wdata_q     <= wdata_d;
      ram_en_q    <= ram_en_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign gnt_id        = gnt_q;
  assign ram_en        = ram_en_q;
  assign ram_read      = ram_read_q;
  assign ram_write     = ram_write_q;
  assign ram_addr      = ram_addr_q;
  assign req_if.ack0   = ack0_q;
  assign req_if.ack1   = ack1_q;
  assign req_if.rdata0 = rdata0_q;
  assign req_if.rdata1 = rdata1_q;

  // Only drive the shared bus during a write; the RAM drives it only under ram_read.
  assign ram_data = ram_write_q ? wdata_q : {DW{1'bz}};

endmodule
